i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter: SAMPLE_W, 24, bits per channel sample; legal range 1..31.
REQ-002 clk  input  1  12 MHz system clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 left_in  input  SAMPLE_W  left sample, two's complement.
REQ-005 right_in  input  SAMPLE_W  right sample, two's complement.
REQ-006 in_valid  input  1  left_in/right_in hold a sample pair.
REQ-007 in_ready  output  1  the block can accept a pair this cycle.
REQ-008 scki  output  1  DAC system clock; equals clk (256*Fs).
REQ-009 bck  output  1  bit clock; clk/4 (64*Fs).
REQ-010 lrck  output  1  word clock; clk/256; low = left, high = right.
REQ-011 dout  output  1  serial data to the DAC.
REQ-012 sample_taken  output  1  one-cycle pulse when the holding buffer moves to the active registers.
REQ-013 underrun  output  1  sticky flag: a frame started with no buffered pair.

Function
REQ-014 An 8-bit free-running prescaler p SHALL increment every clk and wrap 255->0.
REQ-015 bck SHALL be p[1] and lrck SHALL be p[7]; both are registered or derived directly from register bits, with no other logic.
REQ-016 The slot index SHALL be p[6:2] (32 slots per channel); slot s spans p[6:2]=s.
REQ-017 dout SHALL be a register updated only on the clk edge where p[1:0] goes 3->0 (bck falling); it holds for the whole slot, so the DAC samples it on the bck rising edge.
REQ-018 I2S format: in slot s, dout SHALL be ch[SAMPLE_W-s] for 1<=s<=SAMPLE_W, and 0 for slot 0 and slots SAMPLE_W+1..31.
REQ-019 ch SHALL be the active left register while lrck=0 and the active right register while lrck=1.
REQ-020 A one-entry holding buffer SHALL capture left_in/right_in when in_valid && in_ready, and SHALL then be marked full.
REQ-021 in_ready SHALL be (!full) || frame_load, where frame_load = (p == 255).
REQ-022 On frame_load with the buffer full (before any same-cycle accept), the active registers SHALL load from the buffer, sample_taken SHALL pulse, and full SHALL clear.
REQ-023 On frame_load with a same-cycle accept, the buffer SHALL take the new pair and stay full, while the active registers take the old pair.
REQ-024 On frame_load with the buffer empty, the active registers SHALL load 0, underrun SHALL set and stay set until reset, and sample_taken SHALL stay low.
REQ-025 Latency: a pair accepted at or before p=255 SHALL have its left MSB on dout from the edge where p becomes 4, and its right MSB from the edge where p becomes 132.
REQ-026 in_valid while in_ready=0 SHALL be ignored; the input data need not be held.

Reset
REQ-027 On reset the block SHALL set p=0, bck=0, lrck=0, dout=0, the active registers to 0, buffer empty, in_ready=1, sample_taken=0 and underrun=0, all on the next clk edge.
REQ-028 Reset asserted mid-frame SHALL discard both the buffered pair and the active pair; transmission SHALL restart at slot 0 of the left channel.

Structure
REQ-029 Package i2s_pkg SHALL hold SAMPLE_W default, SLOTS_PER_CH=32, PRESCALE_W=8 and the slot-index helper constants, shared with the receiver.
REQ-030 Prescaler/bck/lrck/scki generation SHALL be the sub-module i2s_clkgen, so that receiver and transmitter can share one clock source.
REQ-031 All registers SHALL be clocked by clk only; no logic SHALL be clocked by bck.

Verification
REQ-032 Reset, then run 512 clk with in_valid=0: bck period 4 clk, lrck period 256 clk, dout=0 throughout, underrun=1 after the first p=255.
REQ-033 Send left=24'h800001, right=24'h7FFFFE before p=255; the bench deserializes on bck rising edges and SHALL recover exactly 24'h800001 and 24'h7FFFFE, with left MSB on dout at p=4.
REQ-034 Hold in_valid=1 continuously: exactly one accept and one sample_taken per 256 clk, and no underrun after the first frame.
REQ-035 Drive in_valid at p=255 with the buffer full: the accept happens, the buffer holds the new pair, and the previous pair is transmitted next.
REQ-036 Assert reset at p=70 mid-left-word: on the following cycle dout=0 and p=0; the pending pair is not transmitted; in_ready=1.
REQ-037 Use SAMPLE_W=16 and sample 16'hA5A5: slots 1..16 carry A5A5 MSB first, and slots 17..31 are 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg: frame geometry shared by the I2S transmitter and receiver. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package i2s_pkg;

  localparam int SAMPLE_W_DEF = 24;
  localparam int SLOTS_PER_CH = 32;
  localparam int PRESCALE_W   = 8;

  // Prescaler bit positions: bck, slot index and word clock
  localparam int BCK_BIT  = 1;
  localparam int SLOT_LSB = 2;
  localparam int SLOT_MSB = 6;
  localparam int LRCK_BIT = 7;

  localparam logic [PRESCALE_W-1:0] FRAME_LAST = '1;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

endpackage

`default_nettype wire

// File: rtl/i2s_clkgen.sv
// ---------------------------------------------------------------------------
// i2s_clkgen: free-running prescaler producing scki, bck and lrck. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2s_clkgen
  import i2s_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  output logic [PRESCALE_W-1:0] p,
  output logic                  scki,
  output logic                  bck,
  output logic                  lrck
);

  always_ff @(posedge clk) begin
    if (reset) p <= '0;
    else       p <= p + PRESCALE_W'(1);
  end

  // Clocks are plain register bits so every consumer sees glitch-free edges
  assign bck  = p[BCK_BIT];
  assign lrck = p[LRCK_BIT];
  assign scki = clk;

endmodule

`default_nettype wire

// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx: I2S serializer with a one-pair holding buffer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                scki,
  output logic                bck,
  output logic                lrck,
  output logic                dout,
  output logic                sample_taken,
  output logic                underrun
);

  localparam logic [5:0] SAMPLE_W6 = 6'(SAMPLE_W);

  logic [PRESCALE_W-1:0] p;
  logic [PRESCALE_W-1:0] p_next;
  logic                  full;
  logic [SAMPLE_W-1:0]   buf_l, buf_r;
  logic [SAMPLE_W-1:0]   act_l, act_r;
  logic                  frame_load;
  logic                  accept;
  logic                  bit_edge;
  logic [5:0]            slot_next;
  logic [5:0]            bit_shift;
  logic                  in_word;
  chan_e                 chan_next;
  logic [SAMPLE_W-1:0]   ch;
  logic [SAMPLE_W-1:0]   ch_shifted;
  logic                  ser_bit;

  i2s_clkgen u_clkgen (
    .clk   (clk),
    .reset (reset),
    .p     (p),
    .scki  (scki),
    .bck   (bck),
    .lrck  (lrck)
  );

  assign frame_load = (p == FRAME_LAST);
  assign in_ready   = !full || frame_load;
  assign accept     = in_valid && in_ready;
  assign bit_edge   = (p[BCK_BIT:0] == 2'b11);

  // dout is loaded one edge ahead, so the bit is chosen from the slot about to begin
  assign p_next     = p + PRESCALE_W'(1);
  assign slot_next  = {1'b0, p_next[SLOT_MSB:SLOT_LSB]};
  assign chan_next  = chan_e'(p_next[LRCK_BIT]);
  assign ch         = (chan_next == CH_RIGHT) ? act_r : act_l;
  assign in_word    = (slot_next != 6'd0) && (slot_next <= SAMPLE_W6);
  assign bit_shift  = SAMPLE_W6 - slot_next;
  assign ch_shifted = ch >> bit_shift;
  assign ser_bit    = in_word && ch_shifted[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      full         <= 1'b0;
      buf_l        <= '0;
      buf_r        <= '0;
      act_l        <= '0;
      act_r        <= '0;
      dout         <= 1'b0;
      sample_taken <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      sample_taken <= frame_load && full;

      if (frame_load) begin
        if (full) begin
          act_l <= buf_l;
          act_r <= buf_r;
        end else begin
          act_l    <= '0;
          act_r    <= '0;
          underrun <= 1'b1;
        end
      end

      // A same-cycle accept refills the buffer after its old contents moved out
      if (accept) begin
        buf_l <= left_in;
        buf_r <= right_in;
        full  <= 1'b1;
      end else if (frame_load) begin
        full <= 1'b0;
      end

      if (bit_edge) dout <= ser_bit;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx: self-checking bench for i2s_tx against a frame-level model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] left_in, right_in;
  logic        in_valid;
  logic        in_ready, scki, bck, lrck, dout, sample_taken, underrun;

  logic [15:0] left16, right16;
  logic        valid16;
  logic        ready16, scki16, bck16, lrck16, dout16, taken16, under16;

  always #5 clk = ~clk;

  i2s_tx #(.SAMPLE_W(24)) dut (
    .clk(clk), .reset(reset), .left_in(left_in), .right_in(right_in),
    .in_valid(in_valid), .in_ready(in_ready), .scki(scki), .bck(bck),
    .lrck(lrck), .dout(dout), .sample_taken(sample_taken), .underrun(underrun)
  );

  i2s_tx #(.SAMPLE_W(16)) dut16 (
    .clk(clk), .reset(reset), .left_in(left16), .right_in(right16),
    .in_valid(valid16), .in_ready(ready16), .scki(scki16), .bck(bck16),
    .lrck(lrck16), .dout(dout16), .sample_taken(taken16), .underrun(under16)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
    logic        exp_msb;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Frame-level reference: prescaler phase, pending pairs, pair on the wire
  int          mp = 0;
  logic [23:0] mq_l[$];
  logic [23:0] mq_r[$];
  logic [23:0] m_act_l = '0, m_act_r = '0;
  logic        m_under = 1'b0, m_taken = 1'b0;

  logic fr_cur[256], fr_last[256], fr16_cur[256], fr16_last[256];
  int   n_acc, n_taken;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h p=%0d t=%0t", name, act, exp, mp, $time);
    end
  endtask

  function automatic logic exp_bit(input int pp, input logic [23:0] l, input logic [23:0] r);
    int s;
    logic [23:0] ch;
    s  = (pp / 4) % 32;
    ch = (pp >= 128) ? r : l;
    if (s >= 1 && s <= 24) return ch[24-s];
    return 1'b0;
  endfunction

  task automatic tick();
    logic fl, rdy, acc;
    if (in_valid && in_ready) n_acc++;
    if (reset) begin
      mp = 0;
      mq_l.delete(); mq_r.delete();
      m_act_l = '0; m_act_r = '0;
      m_under = 1'b0; m_taken = 1'b0;
    end else begin
      fl  = (mp == 255);
      rdy = (mq_l.size() == 0) || fl;
      acc = in_valid && rdy;
      m_taken = 1'b0;
      if (fl) begin
        if (mq_l.size() > 0) begin
          m_act_l = mq_l.pop_front();
          m_act_r = mq_r.pop_front();
          m_taken = 1'b1;
        end else begin
          m_act_l = '0; m_act_r = '0;
          m_under = 1'b1;
        end
      end
      if (acc) begin
        mq_l.push_back(left_in);
        mq_r.push_back(right_in);
      end
      mp = (mp + 1) % 256;
    end
    @(posedge clk);
    #1;
    chk("scki", 32'(scki), 32'(clk));
    chk("bck", 32'(bck), (mp >> 1) & 1);
    chk("lrck", 32'(lrck), (mp >> 7) & 1);
    chk("dout", 32'(dout), 32'(exp_bit(mp, m_act_l, m_act_r)));
    chk("in_ready", 32'(in_ready), 32'((mq_l.size() == 0) || (mp == 255)));
    chk("sample_taken", 32'(sample_taken), 32'(m_taken));
    chk("underrun", 32'(underrun), 32'(m_under));
    if (sample_taken) n_taken++;
    fr_cur[mp]   = dout;
    fr16_cur[mp] = dout16;
    if (mp == 255) begin
      fr_last   = fr_cur;
      fr16_last = fr16_cur;
    end
  endtask

  task automatic wait_p(input int target);
    int guard = 0;
    while (mp != target && guard < 300) begin
      tick();
      guard++;
    end
    if (mp != target) begin
      checks++;
      failures++;
      $display("FAIL wait_p actual=%0d required=%0d", mp, target);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Deserialize the last full frame on bck rising edges (p = 4*s + 2)
  task automatic words24(output logic [23:0] l, output logic [23:0] r);
    for (int s = 1; s <= 24; s++) begin
      l[24-s] = fr_last[4*s + 2];
      r[24-s] = fr_last[128 + 4*s + 2];
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    logic [23:0] wl, wr;
    logic [15:0] w16l, w16r;
    logic        zeros16, prev_b, prev_lr;
    int          nb, nlr;

    vecs[0] = '{24'h800001, 24'h7FFFFE, 24'h800001, 24'h7FFFFE, 1'b1};
    vecs[1] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, 1'b1};
    vecs[2] = '{24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF, 1'b0};
    vecs[3] = '{24'h000001, 24'h800000, 24'h000001, 24'h800000, 1'b0};
    vecs[4] = '{24'h5A5A5A, 24'hC3C3C3, 24'h5A5A5A, 24'hC3C3C3, 1'b0};

    reset = 1'b1; in_valid = 1'b0; left_in = '0; right_in = '0;
    valid16 = 1'b0; left16 = '0; right16 = '0;
    n_acc = 0; n_taken = 0;

    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_bck_lrck", {30'd0, bck, lrck}, 0);
    chk("rst_underrun", 32'(underrun), 0);
    reset = 1'b0;

    // Idle: clocks run, data stays zero, underrun sets at the first frame boundary
    nb = 0; nlr = 0;
    for (int i = 0; i < 512; i++) begin
      prev_b = bck; prev_lr = lrck;
      tick();
      if (!prev_b && bck) nb++;
      if (!prev_lr && lrck) nlr++;
    end
    chk("idle_bck_rises", nb, 128);
    chk("idle_lrck_rises", nlr, 2);
    chk("idle_underrun", 32'(underrun), 1);

    // Table-driven pairs; the first also carries the 16-bit sample to dut16
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wait_p(10);
      left_in = vecs[i].l; right_in = vecs[i].r; in_valid = 1'b1;
      if (i == 0) begin
        left16 = 16'hA5A5; right16 = 16'h5A5A; valid16 = 1'b1;
      end
      tick();
      in_valid = 1'b0; valid16 = 1'b0;
      left_in = 24'($urandom); right_in = 24'($urandom);
      wait_p(4);
      chk("msb_at_p4", 32'(dout), 32'(vecs[i].exp_msb));
      wait_p(255);
      words24(wl, wr);
      chk("vec_left", wl, vecs[i].exp_l);
      chk("vec_right", wr, vecs[i].exp_r);
      if (i == 0) begin
        zeros16 = fr16_last[2] | fr16_last[130];
        for (int s = 1; s <= 16; s++) begin
          w16l[16-s] = fr16_last[4*s + 2];
          w16r[16-s] = fr16_last[128 + 4*s + 2];
        end
        for (int s = 17; s <= 31; s++)
          zeros16 = zeros16 | fr16_last[4*s + 2] | fr16_last[128 + 4*s + 2];
        chk("w16_left", w16l, 16'hA5A5);
        chk("w16_right", w16r, 16'h5A5A);
        chk("w16_pad_zero", 32'(zeros16), 0);
      end
    end

    // Accept at p=255 with the buffer full: old pair goes out first, new pair next
    do_reset();
    wait_p(5);
    left_in = 24'h111111; right_in = 24'h222222; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_p(255);
    chk("ready_at_255", 32'(in_ready), 1);
    left_in = 24'h333333; right_in = 24'h444444; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("taken_at_load", 32'(sample_taken), 1);
    chk("buffer_stays_full", 32'(in_ready), 0);
    wait_p(255);
    words24(wl, wr);
    chk("old_pair_left", wl, 24'h111111);
    chk("old_pair_right", wr, 24'h222222);
    tick();
    wait_p(255);
    words24(wl, wr);
    chk("new_pair_left", wl, 24'h333333);
    chk("new_pair_right", wr, 24'h444444);

    // Continuous valid: one accept and one load per frame in steady state
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      left_in = 24'($urandom); right_in = 24'($urandom);
      tick();
    end
    n_acc = 0; n_taken = 0;
    for (int i = 0; i < 512; i++) begin
      left_in = 24'($urandom); right_in = 24'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("stream_accepts", n_acc, 2);
    chk("stream_taken", n_taken, 2);
    chk("stream_no_underrun", 32'(underrun), 0);

    // Reset mid-left-word drops both the active and the buffered pair
    do_reset();
    wait_p(5);
    left_in = 24'hFFFFFF; right_in = 24'hFFFFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_p(255);
    tick();
    wait_p(5);
    left_in = 24'hF0F0F0; right_in = 24'h0F0F0F; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_p(70);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_dout", 32'(dout), 0);
    chk("midrst_clocks", {30'd0, bck, lrck}, 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    wait_p(255);
    words24(wl, wr);
    chk("midrst_frame0", {8'd0, wl | wr}, 0);
    tick();
    wait_p(255);
    words24(wl, wr);
    chk("midrst_frame1", {8'd0, wl | wr}, 0);

    // Randomized traffic: sparse valids, some aimed at the frame boundary
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 99) < 2) || ((mp == 255) && ($urandom_range(0, 1) == 0));
      left_in  = 24'($urandom);
      right_in = 24'($urandom);
      tick();
    end
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
